// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the gate tester: FSM states, lane map, popcount helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_tester_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NUM_GATES   = 7;
   localparam int NUM_VECTORS = 4;

   // Lane index of each gate in a_out/b_out and in fail_mask
   localparam int AND_L  = 0;
   localparam int OR_L   = 1;
   localparam int NOT_L  = 2;
   localparam int NAND_L = 3;
   localparam int NOR_L  = 4;
   localparam int XOR_L  = 5;
   localparam int XNOR_L = 6;

   // Number of set bits in a seven-lane mismatch vector (0..7)
   function automatic logic [2:0] popcount7(input logic [NUM_GATES-1:0] v);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < NUM_GATES; i++) begin
         c = c + {2'b00, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/gate_tester_gate_model.sv
// Reference model: expected result of every gate lane for one (va, vb) vector.
// Latency: purely combinational, no state.
// Backpressure: none.
module gate_model
   import gate_tester_pkg::*;
(
   input  logic                 va,
   input  logic                 vb,
   output logic [NUM_GATES-1:0] exp_res
);

   // Golden truth table; NOT only looks at the A stimulus
   always_comb begin
      exp_res         = '0;
      exp_res[AND_L]  = va & vb;
      exp_res[OR_L]   = va | vb;
      exp_res[NOT_L]  = ~va;
      exp_res[NAND_L] = ~(va & vb);
      exp_res[NOR_L]  = ~(va | vb);
      exp_res[XOR_L]  = va ^ vb;
      exp_res[XNOR_L] = ~(va ^ vb);
   end

endmodule

// File: rtl/gate_tester.sv
// Exhaustive 2-input tester for seven gate lanes; counts and flags mismatching (vector, gate) pairs.
// Latency: 4*(SETTLE_CYCLES+1) cycles from start to done; all outputs registered.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
module gate_tester
   import gate_tester_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [NUM_GATES-1:0] a_out,
   output logic [NUM_GATES-1:0] b_out,
   input  logic                 and_in,
   input  logic                 or_in,
   input  logic                 not_in,
   input  logic                 nand_in,
   input  logic                 nor_in,
   input  logic                 xor_in,
   input  logic                 xnor_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [4:0]           err_count,
   output logic [NUM_GATES-1:0] fail_mask
);

   state_t                 state_q, state_d;
   logic [1:0]             vec_idx_q, vec_idx_d;
   logic [3:0]             settle_q, settle_d;
   logic [4:0]             err_count_q, err_count_d;
   logic [NUM_GATES-1:0]   fail_mask_q, fail_mask_d;
   logic [NUM_GATES-1:0]   a_out_q, a_out_d;
   logic [NUM_GATES-1:0]   b_out_q, b_out_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;

   logic [NUM_GATES-1:0]   exp_res;
   logic [NUM_GATES-1:0]   dut_res;
   logic [NUM_GATES-1:0]   mism;

   // Expected results follow the vector currently held on a_out/b_out
   gate_model u_gate_model (
      .va      (vec_idx_q[1]),
      .vb      (vec_idx_q[0]),
      .exp_res (exp_res)
   );

   assign dut_res = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
   assign mism    = dut_res ^ exp_res;

   // Next-state and next-output computation for the test sequencer
   always_comb begin
      state_d     = state_q;
      vec_idx_d   = vec_idx_q;
      settle_d    = settle_q;
      err_count_d = err_count_q;
      fail_mask_d = fail_mask_q;
      a_out_d     = a_out_q;
      b_out_d     = b_out_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = DRIVE;
               vec_idx_d   = 2'd0;
               settle_d    = 4'd0;
               err_count_d = '0;
               fail_mask_d = '0;
               a_out_d     = '0;
               b_out_d     = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
            end
         end
         DRIVE: begin
            if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
               state_d = CHECK;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         CHECK: begin
            // Max 7 mismatches per vector over 4 vectors, so 5 bits never overflow
            err_count_d = err_count_q + {2'b00, popcount7(mism)};
            fail_mask_d = fail_mask_q | mism;
            if (vec_idx_q == 2'(NUM_VECTORS - 1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_count_d == 5'd0);
            end else begin
               state_d   = DRIVE;
               vec_idx_d = vec_idx_q + 2'd1;
               settle_d  = 4'd0;
               a_out_d   = {NUM_GATES{vec_idx_d[1]}};
               b_out_d   = {NUM_GATES{vec_idx_d[0]}};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state and outputs registered; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_idx_q   <= '0;
         settle_q    <= '0;
         err_count_q <= '0;
         fail_mask_q <= '0;
         a_out_q     <= '0;
         b_out_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_idx_q   <= vec_idx_d;
         settle_q    <= settle_d;
         err_count_q <= err_count_d;
         fail_mask_q <= fail_mask_d;
         a_out_q     <= a_out_d;
         b_out_q     <= b_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   assign a_out     = a_out_q;
   assign b_out     = b_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two testers (settle 1 and settle 3) drive faultable behavioural gate lanes.
// Latency: expectations are queued at start and checked when done rises.
// Backpressure: none.
module tb_gate_tester;

   typedef struct {
      int err;
      int mask;
      int pass;
      int cycles;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n0, rst_n1, start0, start1;
   logic [6:0] a0, b0, a1, b1, r0, r1, m0, m1;
   logic       busy0, busy1, done0, done1, pass0, pass1;
   logic [4:0] e0, e1;
   int         mode0, mode1;
   int         tests = 0;
   int         fails = 0;
   int         bc0 = 0;
   int         bc1 = 0;
   logic       dp0 = 1'b0;
   logic       dp1 = 1'b0;
   exp_t       q0[$];
   exp_t       q1[$];

   always #5 clk = ~clk;

   // Behavioural gate lanes; lane i sees only a[i], b[i]
   function automatic logic [6:0] gates(input int mode, input logic [6:0] a, input logic [6:0] b);
      logic [6:0] c;
      c[0] = a[0] & b[0];
      c[1] = a[1] | b[1];
      c[2] = ~a[2];
      c[3] = ~(a[3] & b[3]);
      c[4] = ~(a[4] | b[4]);
      c[5] = a[5] ^ b[5];
      c[6] = ~(a[6] ^ b[6]);
      case (mode)
         1: c[0] = 1'b0;                  // and stuck at 0
         2: c[2] = a[2];                  // not wired as buffer
         3: c = {c[5], c[6], c[4:0]};     // xor/xnor swapped
         4: c = ~c;                       // everything inverted
         default: ;
      endcase
      return c;
   endfunction

   assign r0 = gates(mode0, a0, b0);
   assign r1 = gates(mode1, a1, b1);

   gate_tester #(.SETTLE_CYCLES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n0), .start(start0), .a_out(a0), .b_out(b0),
      .and_in(r0[0]), .or_in(r0[1]), .not_in(r0[2]), .nand_in(r0[3]),
      .nor_in(r0[4]), .xor_in(r0[5]), .xnor_in(r0[6]),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(e0), .fail_mask(m0)
   );

   gate_tester #(.SETTLE_CYCLES(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .start(start1), .a_out(a1), .b_out(b1),
      .and_in(r1[0]), .or_in(r1[1]), .not_in(r1[2]), .nand_in(r1[3]),
      .nor_in(r1[4]), .xor_in(r1[5]), .xnor_in(r1[6]),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(e1), .fail_mask(m1)
   );

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor for tester 0: counts busy cycles, pops and checks on done rising
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n0) begin
         bc0 = 0;
      end else begin
         if (busy0) bc0++;
         if (!done0) chk("pass_low_0", int'(pass0), 0);
         if (done0 && !dp0) begin
            if (q0.size() == 0) begin
               chk("unexpected_done_0", 1, 0);
            end else begin
               e = q0.pop_front();
               chk("err_count_0", int'(e0), e.err);
               chk("fail_mask_0", int'(m0), e.mask);
               chk("pass_0", int'(pass0), e.pass);
               chk("busy_cycles_0", bc0, e.cycles);
            end
            bc0 = 0;
         end
      end
      dp0 = done0;
   end

   // Monitor for tester 1 (settle 3)
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n1) begin
         bc1 = 0;
      end else begin
         if (busy1) bc1++;
         if (!done1) chk("pass_low_1", int'(pass1), 0);
         if (done1 && !dp1) begin
            if (q1.size() == 0) begin
               chk("unexpected_done_1", 1, 0);
            end else begin
               e = q1.pop_front();
               chk("err_count_1", int'(e1), e.err);
               chk("fail_mask_1", int'(m1), e.mask);
               chk("pass_1", int'(pass1), e.pass);
               chk("busy_cycles_1", bc1, e.cycles);
            end
            bc1 = 0;
         end
      end
      dp1 = done1;
   end

   task automatic set_start(input int inst, input logic v);
      if (inst == 0) start0 = v;
      else start1 = v;
   endtask

   task automatic pulse(input int inst);
      @(posedge clk); #1 set_start(inst, 1'b1);
      @(posedge clk); #1 set_start(inst, 1'b0);
   endtask

   // Queue the expectation, run one test, wait (bounded) for done
   task automatic run(input int inst, input int mode, input int err, input int mask,
                      input int ps, input bit repulse);
      exp_t e;
      int   n;
      e.err = err; e.mask = mask; e.pass = ps;
      e.cycles = (inst == 0) ? 8 : 16;
      if (inst == 0) begin mode0 = mode; q0.push_back(e); end
      else begin mode1 = mode; q1.push_back(e); end
      pulse(inst);
      if (repulse) begin
         repeat (2) @(posedge clk);
         #1 set_start(inst, 1'b1);
         @(posedge clk); #1 set_start(inst, 1'b0);
      end
      n = 0;
      while (!((inst == 0) ? done0 : done1) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("done_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_idle0(input string nm);
      chk({nm, "_a"},    int'(a0), 0);
      chk({nm, "_b"},    int'(b0), 0);
      chk({nm, "_busy"}, int'(busy0), 0);
      chk({nm, "_done"}, int'(done0), 0);
      chk({nm, "_pass"}, int'(pass0), 0);
      chk({nm, "_err"},  int'(e0), 0);
      chk({nm, "_mask"}, int'(m0), 0);
   endtask

   initial begin
      int n;
      rst_n0 = 1'b0; rst_n1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
      mode0 = 0; mode1 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle0("reset0");
      chk("reset1_busy", int'(busy1), 0);
      chk("reset1_done", int'(done1), 0);
      chk("reset1_a", int'(a1), 0);
      rst_n0 = 1'b1; rst_n1 = 1'b1;

      run(0, 0, 0,  7'h00, 1, 1'b0);   // correct gates
      run(0, 1, 1,  7'h01, 0, 1'b0);   // and stuck 0
      run(0, 2, 4,  7'h04, 0, 1'b0);   // not = va
      run(0, 3, 8,  7'h60, 0, 1'b0);   // xor/xnor swapped
      run(0, 4, 28, 7'h7F, 0, 1'b0);   // all inverted
      run(0, 0, 0,  7'h00, 1, 1'b1);   // start re-pulsed mid-run

      // Reset while vector 10 is applied; start held during reset must not launch
      mode0 = 0;
      pulse(0);
      n = 0;
      while (!(a0 == 7'h7F && b0 == 7'h00) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("vec10_timeout", 0, 1);
      rst_n0 = 1'b0; start0 = 1'b1;
      @(posedge clk); #1;
      chk_idle0("midrun_reset");
      @(posedge clk); #1;
      chk("reset_start_ignored", int'(busy0), 0);
      start0 = 1'b0; rst_n0 = 1'b1;
      run(0, 0, 0, 7'h00, 1, 1'b0);

      run(1, 0, 0, 7'h00, 1, 1'b0);    // settle 3, correct
      run(1, 2, 4, 7'h04, 0, 1'b0);    // failing run ...
      run(1, 0, 0, 7'h00, 1, 1'b0);    // ... cleared by start in DONE

      repeat (4) @(posedge clk);
      chk("queue0_empty", q0.size(), 0);
      chk("queue1_empty", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
